riscv_coredpathrespqueue: RTL and testbench

- Parametrised data-memory response queue for the bypassing RISC-V core. It replaces the fixed one-entry 32-bit response register and its select mux.
- Accepts raw memory response words and performs subword load extraction, including the byte-offset shift that the old path lacked.
- Buffers up to DEPTH responses and delivers them to the M-stage writeback mux through a val/rdy handshake.
- Zero-latency pass-through when empty; synchronous flush for squashed loads.

---
 rtl/riscv_coredpathrespqueue_pkg.sv | 14 +
 rtl/riscv_coredpathrespqueue_if.sv | 20 ++
 rtl/riscv_coredpathrespqueue_extract.sv | 29 ++
 rtl/riscv_coredpathrespqueue.sv | 56 +++++
 tb/tb_riscv_coredpathrespqueue.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/riscv_coredpathrespqueue_pkg.sv
// riscv_coredpathrespqueue_pkg: load-extraction function encodings shared with the
// control unit's dmemresp mux select.
package riscv_coredpathrespqueue_pkg;
    typedef enum logic [2:0] {
        FN_FULL = 3'd0,
        FN_LB   = 3'd1,
        FN_LBU  = 3'd2,
        FN_LH   = 3'd3,
        FN_LHU  = 3'd4,
        FN_LW   = 3'd5,
        FN_LWU  = 3'd6,
        FN_ZERO = 3'd7
    } load_fn_e;
endpackage

// File: rtl/riscv_coredpathrespqueue_if.sv
// riscv_coredpathrespqueue_if: enqueue/dequeue handshake, flush and occupancy
// between data memory, the response queue and the writeback mux.
interface riscv_coredpathrespqueue_if #(parameter int DATA_W = 32, parameter int DEPTH = 4);
    localparam int OFFS_W = $clog2(DATA_W / 8);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    logic              enq_val;
    logic              enq_rdy;
    logic [DATA_W-1:0] enq_data;
    logic [2:0]        enq_fn;
    logic [OFFS_W-1:0] enq_offset;
    logic              deq_val;
    logic              deq_rdy;
    logic [DATA_W-1:0] deq_data;
    logic              flush;
    logic [CNT_W-1:0]  count;
    modport master (output enq_val, enq_data, enq_fn, enq_offset, deq_rdy, flush,
                    input enq_rdy, deq_val, deq_data, count);
    modport slave  (input enq_val, enq_data, enq_fn, enq_offset, deq_rdy, flush,
                    output enq_rdy, deq_val, deq_data, count);
endinterface

// File: rtl/riscv_coredpathrespqueue_extract.sv
// riscv_coredpathrespqueue_extract: subword load extraction with byte-offset shift
// and sign/zero extension to the memory word width.
module riscv_coredpathrespqueue_extract
    import riscv_coredpathrespqueue_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int OFFS_W = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [2:0]        fn,
    input  logic [OFFS_W-1:0] offset,
    output logic [DATA_W-1:0] result
);
    logic [OFFS_W-1:0] oh, ow;
    logic [DATA_W-1:0] sb, sh, sw;
    // halves and words ignore the offset bits below their natural alignment
    assign oh = offset & ~OFFS_W'(1);
    assign ow = offset & ~OFFS_W'(3);
    assign sb = data >> {offset, 3'b000};
    assign sh = data >> {oh, 3'b000};
    assign sw = data >> {ow, 3'b000};
    assign result = fn == FN_LB  ? DATA_W'($signed(sb[7:0]))  :
                    fn == FN_LBU ? DATA_W'(sb[7:0])           :
                    fn == FN_LH  ? DATA_W'($signed(sh[15:0])) :
                    fn == FN_LHU ? DATA_W'(sh[15:0])          :
                    fn == FN_LW  ? DATA_W'($signed(sw[31:0])) :
                    fn == FN_LWU ? DATA_W'(sw[31:0])          :
                    fn == FN_FULL ? data : '0;
endmodule

// File: rtl/riscv_coredpathrespqueue.sv
// riscv_coredpathrespqueue: data-memory response FIFO with enqueue-side extraction,
// zero-latency bypass when empty and synchronous flush.
module riscv_coredpathrespqueue
    import riscv_coredpathrespqueue_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input logic clk,
    input logic reset,
    riscv_coredpathrespqueue_if.slave q
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ext;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              empty, deq_fire, enq_fire, buf_deq;
    riscv_coredpathrespqueue_extract #(.DATA_W(DATA_W)) u_extract (
        .data   (q.enq_data),
        .fn     (q.enq_fn),
        .offset (q.enq_offset),
        .result (ext)
    );
    assign empty      = cnt == '0;
    assign q.enq_rdy  = reset && cnt != CNT_W'(DEPTH) && !q.flush;
    assign q.deq_val  = reset && !q.flush && (empty ? q.enq_val : 1'b1);
    assign q.deq_data = empty ? ext : mem[rd_ptr];
    assign q.count    = cnt;
    assign deq_fire   = q.deq_val && q.deq_rdy;
    // a word consumed straight through while empty is never stored
    assign enq_fire   = q.enq_val && q.enq_rdy && !(empty && deq_fire);
    assign buf_deq    = deq_fire && !empty;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (q.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(buf_deq);
            wr_ptr <= wr_ptr + PTR_W'(enq_fire);
            cnt    <= cnt + CNT_W'(enq_fire) - CNT_W'(buf_deq);
        end
    end
    always_ff @(posedge clk) begin
        if (enq_fire) mem[wr_ptr] <= ext;
    end
    // a flushed word is dropped, so offering it against a flush is legal
    a_enq_protocol: assert property (@(posedge clk) disable iff (!reset)
        q.enq_val && !q.flush |-> q.enq_rdy);
endmodule

// File: tb/tb_riscv_coredpathrespqueue.sv
// tb_riscv_coredpathrespqueue: directed checks of bypass, FIFO order, wrap,
// extraction (32/64-bit), flush and asynchronous reset.
module tb_riscv_coredpathrespqueue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    riscv_coredpathrespqueue_if #(.DATA_W(32)) q32 ();
    riscv_coredpathrespqueue_if #(.DATA_W(64)) q64 ();
    riscv_coredpathrespqueue #(.DATA_W(32)) d32 (.clk(clk), .reset(rst_n), .q(q32));
    riscv_coredpathrespqueue #(.DATA_W(64)) d64 (.clk(clk), .reset(rst_n), .q(q64));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        q32.enq_val = 0; q32.enq_data = '0; q32.enq_fn = 0; q32.enq_offset = 0;
        q32.deq_rdy = 0; q32.flush = 0;
        q64.enq_val = 0; q64.enq_data = '0; q64.enq_fn = 0; q64.enq_offset = 0;
        q64.deq_rdy = 0; q64.flush = 0;
        #2;
        chk("rst_count", 64'(q32.count), 64'd0);
        chk("rst_deq_val", 64'(q32.deq_val), 64'd0);
        chk("rst_enq_rdy", 64'(q32.enq_rdy), 64'd0);
        chk("rst_count64", 64'(q64.count), 64'd0);
        #15 rst_n = 1'b1;
        tick();
        // empty bypass of a sign-extended byte
        q32.enq_val = 1; q32.enq_fn = 1; q32.enq_offset = 2; q32.enq_data = 32'h12805678; q32.deq_rdy = 1;
        #1;
        chk("byp_val", 64'(q32.deq_val), 64'd1);
        chk("byp_data", 64'(q32.deq_data), 64'hFFFFFF80);
        tick();
        chk("byp_count", 64'(q32.count), 64'd0);
        // fill to full
        q32.deq_rdy = 0; q32.enq_fn = 0; q32.enq_offset = 0;
        for (int i = 1; i <= 4; i++) begin
            q32.enq_data = 32'(i);
            tick();
        end
        q32.enq_val = 0;
        #1;
        chk("full_count", 64'(q32.count), 64'd4);
        chk("full_enq_rdy", 64'(q32.enq_rdy), 64'd0);
        q32.deq_rdy = 1;
        #1;
        chk("full_deqrdy_enq_rdy", 64'(q32.enq_rdy), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_data", 64'(q32.deq_data), 64'(i));
            tick();
        end
        chk("drain_count", 64'(q32.count), 64'd0);
        chk("drain_deq_val", 64'(q32.deq_val), 64'd0);
        // steady enqueue/dequeue at count 2, pointers wrap
        q32.deq_rdy = 0; q32.enq_val = 1;
        q32.enq_data = 32'd10; tick();
        q32.enq_data = 32'd11; tick();
        q32.deq_rdy = 1;
        for (int k = 0; k < 8; k++) begin
            q32.enq_data = 32'(12 + k);
            #1;
            chk("sim_data", 64'(q32.deq_data), 64'(10 + k));
            tick();
            chk("sim_count", 64'(q32.count), 64'd2);
        end
        q32.enq_val = 0;
        chk("sim_tail0", 64'(q32.deq_data), 64'd18);
        tick();
        chk("sim_tail1", 64'(q32.deq_data), 64'd19);
        tick();
        chk("sim_empty", 64'(q32.count), 64'd0);
        // extraction sweep through the bypass path
        q32.enq_val = 1; q32.enq_data = 32'hA1B2C3D4;
        q32.enq_fn = 4; q32.enq_offset = 2; #1;
        chk("ext_lhu2", 64'(q32.deq_data), 64'h0000A1B2);
        q32.enq_fn = 3; q32.enq_offset = 3; #1;
        chk("ext_lh3", 64'(q32.deq_data), 64'hFFFFA1B2);
        q32.enq_fn = 2; q32.enq_offset = 0; #1;
        chk("ext_lbu0", 64'(q32.deq_data), 64'h000000D4);
        q32.enq_fn = 7; #1;
        chk("ext_fn7", 64'(q32.deq_data), 64'h0);
        q32.enq_fn = 5; q32.enq_offset = 1; #1;
        chk("ext_lw32", 64'(q32.deq_data), 64'hA1B2C3D4);
        q32.enq_fn = 0; q32.enq_val = 0;
        q64.enq_val = 1; q64.deq_rdy = 1; q64.enq_data = 64'h80000000_00000001;
        q64.enq_fn = 5; q64.enq_offset = 4; #1;
        chk("ext64_lw4", q64.deq_data, 64'hFFFFFFFF80000000);
        q64.enq_fn = 6; #1;
        chk("ext64_lwu4", q64.deq_data, 64'h0000000080000000);
        q64.enq_fn = 1; q64.enq_offset = 0; #1;
        chk("ext64_lb0", q64.deq_data, 64'h1);
        tick();
        q64.enq_val = 0;
        chk("ext64_count", 64'(q64.count), 64'd0);
        // flush at count 3 with a word on offer
        q32.deq_rdy = 0; q32.enq_val = 1;
        for (int i = 21; i <= 23; i++) begin
            q32.enq_data = 32'(i);
            tick();
        end
        chk("pre_flush_count", 64'(q32.count), 64'd3);
        q32.flush = 1; q32.enq_data = 32'd99; #1;
        chk("flush_deq_val", 64'(q32.deq_val), 64'd0);
        chk("flush_enq_rdy", 64'(q32.enq_rdy), 64'd0);
        tick();
        q32.flush = 0; q32.enq_val = 0; #1;
        chk("post_flush_count", 64'(q32.count), 64'd0);
        chk("post_flush_deq_val", 64'(q32.deq_val), 64'd0);
        q32.enq_val = 1; q32.enq_data = 32'd5; q32.deq_rdy = 1; #1;
        chk("post_flush_byp", 64'(q32.deq_data), 64'd5);
        tick();
        chk("post_flush_byp_count", 64'(q32.count), 64'd0);
        // asynchronous reset mid-fill
        q32.deq_rdy = 0;
        q32.enq_data = 32'd31; tick();
        q32.enq_data = 32'd32; tick();
        chk("mid_fill_count", 64'(q32.count), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count", 64'(q32.count), 64'd0);
        chk("async_rst_deq_val", 64'(q32.deq_val), 64'd0);
        q32.enq_val = 0;
        tick();
        #2 rst_n = 1'b1;
        tick();
        q32.enq_val = 1; q32.enq_data = 32'd7; tick();
        q32.enq_val = 0; #1;
        chk("after_rst_count", 64'(q32.count), 64'd1);
        chk("after_rst_data", 64'(q32.deq_data), 64'd7);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
